// File: rtl/wishbone_classic_burst_ctrl_pkg.sv
// Shared types for the Wishbone classic burst controller.
//   state_t         controller FSM states
//   beat_cnt_width  width of the beats-minus-one counter (at least 1 bit)
//   rsp_flags_t     per-beat response flags; the top module pairs this with
//                   the DATA_WIDTH-wide read data to form a full response
package wishbone_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_REQ   = 2'd2,
        ST_RSP   = 2'd3
    } state_t;

    // A single-beat controller still needs a 1-bit length field so the
    // port never collapses to zero width.
    function automatic int beat_cnt_width(input int max_beats);
        if (max_beats > 1) begin
            return $clog2(max_beats);
        end else begin
            return 1;
        end
    endfunction

    typedef struct packed {
        logic err;
        logic timeout;
        logic last;
    } rsp_flags_t;

endpackage

// File: rtl/wishbone_classic_burst_ctrl_watchdog.sv
// Watchdog for a Wishbone strobe that never gets terminated.
//   clk_i, rst_i  clock and synchronous active-high reset
//   clear         hold the counter at zero (controller is not requesting)
//   enable        count while the strobe is outstanding
//   expired       high in the cycle the count reaches TIMEOUT_CYCLES-1;
//                 acting on it at that edge gives exactly TIMEOUT_CYCLES
//                 strobe cycles. Tied low when TIMEOUT_CYCLES is 0.
module wishbone_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_s;
            assign unused_s = ^{clk_i, rst_i, clear, enable};
            assign expired  = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] count_r;

            // Strobe-age counter; saturates at LIMIT until cleared.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    count_r <= {CNT_W{1'b0}};
                end else if (clear) begin
                    count_r <= {CNT_W{1'b0}};
                end else if (enable && (count_r != LIMIT)) begin
                    count_r <= count_r + CNT_W'(1);
                end else begin
                    count_r <= count_r;
                end
            end

            assign expired = enable && (count_r == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/wishbone_classic_burst_ctrl.sv
// Wishbone classic bus controller with incrementing bursts.
// Accepts a command (direction, start word address, beats-1), pulls one
// write-data beat per write transfer, runs each beat as a classic
// cyc/stb cycle with cyc held across the whole burst, and hands back one
// response per beat. A bus error ends the burst early; the watchdog ends
// it when the slave never answers.
//   Command side : cmd_valid/cmd_ready, cmd_we, cmd_addr, cmd_len
//   Write data   : wdata_valid/wdata_ready, wdata
//   Responses    : rsp_valid/rsp_ready, rsp_data, rsp_err, rsp_timeout, rsp_last
//   Wishbone     : cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, dat_i, ack_i, err_i
// Every output is a flop (or a bit of a flopped struct).
module wishbone_classic_burst_ctrl
    import wishbone_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_we,
    input  logic [ADDR_WIDTH-1:0]                  cmd_addr,
    input  logic [beat_cnt_width(MAX_BEATS)-1:0]   cmd_len,
    input  logic                                   wdata_valid,
    output logic                                   wdata_ready,
    input  logic [DATA_WIDTH-1:0]                  wdata,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [DATA_WIDTH-1:0]                  rsp_data,
    output logic                                   rsp_err,
    output logic                                   rsp_timeout,
    output logic                                   rsp_last,
    output logic                                   cyc_o,
    output logic                                   stb_o,
    output logic                                   we_o,
    output logic [ADDR_WIDTH-1:0]                  adr_o,
    output logic [DATA_WIDTH-1:0]                  dat_o,
    output logic [DATA_WIDTH/8-1:0]                sel_o,
    input  logic [DATA_WIDTH-1:0]                  dat_i,
    input  logic                                   ack_i,
    input  logic                                   err_i
);

    localparam int LEN_W = beat_cnt_width(MAX_BEATS);
    localparam int SEL_W = DATA_WIDTH / 8;

    state_t           state_r;
    logic [LEN_W-1:0] remaining_r;
    rsp_flags_t       rsp_flags_r;

    logic wd_enable_s;
    logic wd_clear_s;
    logic wd_expired_s;

    assign rsp_err     = rsp_flags_r.err;
    assign rsp_timeout = rsp_flags_r.timeout;
    assign rsp_last    = rsp_flags_r.last;

    // The watchdog only ages an outstanding strobe; it restarts every beat.
    assign wd_enable_s = (state_r == ST_REQ);
    assign wd_clear_s  = (state_r != ST_REQ);

    wishbone_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // Controller FSM with all bus and handshake outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            remaining_r <= {LEN_W{1'b0}};
            cmd_ready   <= 1'b1;
            wdata_ready <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= {DATA_WIDTH{1'b0}};
            rsp_flags_r <= 3'b000;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= {ADDR_WIDTH{1'b0}};
            dat_o       <= {DATA_WIDTH{1'b0}};
            sel_o       <= {SEL_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        we_o        <= cmd_we;
                        adr_o       <= cmd_addr;
                        remaining_r <= cmd_len;
                        cyc_o       <= 1'b1;
                        sel_o       <= {SEL_W{1'b1}};
                        cmd_ready   <= 1'b0;
                        if (cmd_we) begin
                            state_r     <= ST_WDATA;
                            wdata_ready <= 1'b1;
                        end else begin
                            state_r <= ST_REQ;
                            stb_o   <= 1'b1;
                            dat_o   <= {DATA_WIDTH{1'b0}};
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_WDATA: begin
                    if (wdata_valid) begin
                        dat_o       <= wdata;
                        stb_o       <= 1'b1;
                        wdata_ready <= 1'b0;
                        state_r     <= ST_REQ;
                    end else begin
                        state_r <= ST_WDATA;
                    end
                end

                ST_REQ: begin
                    // err_i wins over a simultaneous ack_i; an error always
                    // ends the burst so no further beats are attempted.
                    if (ack_i || err_i) begin
                        stb_o     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= (!err_i && !we_o) ? dat_i : {DATA_WIDTH{1'b0}};
                        rsp_flags_r.err     <= err_i;
                        rsp_flags_r.timeout <= 1'b0;
                        rsp_flags_r.last    <= (remaining_r == {LEN_W{1'b0}}) || err_i;
                        state_r   <= ST_RSP;
                    end else if (wd_expired_s) begin
                        stb_o       <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= {DATA_WIDTH{1'b0}};
                        rsp_flags_r <= 3'b111;
                        state_r     <= ST_RSP;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_data    <= {DATA_WIDTH{1'b0}};
                        rsp_flags_r <= 3'b000;
                        if (rsp_flags_r.last) begin
                            cyc_o     <= 1'b0;
                            we_o      <= 1'b0;
                            sel_o     <= {SEL_W{1'b0}};
                            cmd_ready <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else begin
                            adr_o       <= adr_o + ADDR_WIDTH'(1);
                            remaining_r <= remaining_r - LEN_W'(1);
                            if (we_o) begin
                                wdata_ready <= 1'b1;
                                state_r     <= ST_WDATA;
                            end else begin
                                stb_o   <= 1'b1;
                                state_r <= ST_REQ;
                            end
                        end
                    end else begin
                        state_r <= ST_RSP;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready   <= 1'b1;
                    wdata_ready <= 1'b0;
                    rsp_valid   <= 1'b0;
                    rsp_flags_r <= 3'b000;
                    cyc_o       <= 1'b0;
                    stb_o       <= 1'b0;
                    we_o        <= 1'b0;
                    sel_o       <= {SEL_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_classic_burst_ctrl.sv
// Directed bench for wishbone_classic_burst_ctrl (watchdog set to 8 cycles).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_wishbone_classic_burst_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        rsp_last;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    int errors = 0;
    int checks = 0;

    wishbone_classic_burst_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MAX_BEATS      (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .rsp_last    (rsp_last),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .sel_o       (sel_o),
        .dat_i       (dat_i),
        .ack_i       (ack_i),
        .err_i       (err_i)
    );

    // 100 MHz clock.
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %0h want 0", cyc_o); end
        checks++; if (stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %0h want 0", stb_o); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0h want 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0h want 0", rsp_valid); end
        checks++; if (adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h want 0", adr_o); end
        checks++; if (sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", sel_o); end
        checks++; if (wdata_ready !== 1'b0) begin errors++; $display("FAIL reset_wdata_ready: got %0h want 0", wdata_ready); end
        rst_i = 1'b0;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %0h want 1", cmd_ready); end
    endtask

    task automatic test_single_read();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h10; cmd_len = 4'd0;
        tick();                                    // cycle 1
        cmd_valid = 1'b0;
        checks++; if (stb_o !== 1'b1) begin errors++; $display("FAIL rd_stb_c1: got %0h want 1", stb_o); end
        checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL rd_cyc_c1: got %0h want 1", cyc_o); end
        checks++; if (adr_o !== 32'h10) begin errors++; $display("FAIL rd_adr: got %h want 00000010", adr_o); end
        checks++; if (sel_o !== 4'hF) begin errors++; $display("FAIL rd_sel: got %h want f", sel_o); end
        checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL rd_we: got %0h want 0", we_o); end
        tick();                                    // cycle 2: slave acks
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_early_rsp: got %0h want 0", rsp_valid); end
        ack_i = 1'b1; dat_i = 32'hCAFE_F00D;
        tick();                                    // cycle 3
        ack_i = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid_c3: got %0h want 1", rsp_valid); end
        checks++; if (rsp_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_rsp_data: got %h want cafef00d", rsp_data); end
        checks++; if (rsp_last !== 1'b1) begin errors++; $display("FAIL rd_rsp_last: got %0h want 1", rsp_last); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp_err: got %0h want 0", rsp_err); end
        checks++; if (stb_o !== 1'b0) begin errors++; $display("FAIL rd_stb_c3: got %0h want 0", stb_o); end
        tick();                                    // cycle 4
        checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL rd_cyc_c4: got %0h want 0", cyc_o); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_cmd_ready_c4: got %0h want 1", cmd_ready); end
    endtask

    task automatic test_write_burst();
        logic [31:0] exp_adr [4];
        logic [31:0] exp_dat [4];
        exp_adr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        exp_dat = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'hFFFF_FFFE; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            checks++; if (wdata_ready !== 1'b1) begin errors++; $display("FAIL wr_wdata_ready[%0d]: got %0h want 1", b, wdata_ready); end
            checks++; if (stb_o !== 1'b0) begin errors++; $display("FAIL wr_stb_wait[%0d]: got %0h want 0", b, stb_o); end
            checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL wr_cyc_wait[%0d]: got %0h want 1", b, cyc_o); end
            if (b == 2) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    checks++; if (stb_o !== 1'b0) begin errors++; $display("FAIL wr_gap_stb[%0d]: got %0h want 0", g, stb_o); end
                    checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL wr_gap_cyc[%0d]: got %0h want 1", g, cyc_o); end
                end
            end
            wdata_valid = 1'b1; wdata = exp_dat[b];
            tick();
            wdata_valid = 1'b0;
            checks++; if (stb_o !== 1'b1) begin errors++; $display("FAIL wr_stb[%0d]: got %0h want 1", b, stb_o); end
            checks++; if (we_o !== 1'b1) begin errors++; $display("FAIL wr_we[%0d]: got %0h want 1", b, we_o); end
            checks++; if (adr_o !== exp_adr[b]) begin errors++; $display("FAIL wr_adr[%0d]: got %h want %h", b, adr_o, exp_adr[b]); end
            checks++; if (dat_o !== exp_dat[b]) begin errors++; $display("FAIL wr_dat[%0d]: got %h want %h", b, dat_o, exp_dat[b]); end
            ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid[%0d]: got %0h want 1", b, rsp_valid); end
            checks++; if (rsp_last !== (b == 3)) begin errors++; $display("FAIL wr_rsp_last[%0d]: got %0h want %0h", b, rsp_last, (b == 3)); end
            checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL wr_rsp_data[%0d]: got %h want 0", b, rsp_data); end
            checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL wr_cyc_rsp[%0d]: got %0h want 1", b, cyc_o); end
            tick();
        end
        checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL wr_cyc_end: got %0h want 0", cyc_o); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready_end: got %0h want 1", cmd_ready); end
    endtask

    task automatic test_read_err();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h100; cmd_len = 4'd2;
        tick();                                    // beat 1 strobe
        cmd_valid = 1'b0;
        ack_i = 1'b1; dat_i = 32'h1111_2222;
        tick();
        ack_i = 1'b0;
        checks++; if (rsp_data !== 32'h1111_2222) begin errors++; $display("FAIL err_b1_data: got %h want 11112222", rsp_data); end
        checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL err_b1_last: got %0h want 0", rsp_last); end
        tick();                                    // beat 2 strobe
        checks++; if (adr_o !== 32'h101) begin errors++; $display("FAIL err_b2_adr: got %h want 00000101", adr_o); end
        err_i = 1'b1;
        tick();
        err_i = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL err_b2_valid: got %0h want 1", rsp_valid); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_b2_err: got %0h want 1", rsp_err); end
        checks++; if (rsp_last !== 1'b1) begin errors++; $display("FAIL err_b2_last: got %0h want 1", rsp_last); end
        checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL err_b2_timeout: got %0h want 0", rsp_timeout); end
        tick();
        checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL err_cyc_end: got %0h want 0", cyc_o); end
        tick();
        checks++; if (stb_o !== 1'b0) begin errors++; $display("FAIL err_no_beat3: got %0h want 0", stb_o); end
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        n = 0; seen = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h20; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (stb_o === 1'b1) n++;
                tick();
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL to_rsp_seen: got %0h want 1 within 20 cycles", seen); end
        checks++; if (n !== 8) begin errors++; $display("FAIL to_stb_cycles: got %0d want 8", n); end
        checks++; if (rsp_timeout !== 1'b1) begin errors++; $display("FAIL to_timeout: got %0h want 1", rsp_timeout); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL to_err: got %0h want 1", rsp_err); end
        checks++; if (rsp_last !== 1'b1) begin errors++; $display("FAIL to_last: got %0h want 1", rsp_last); end
        checks++; if (stb_o !== 1'b0) begin errors++; $display("FAIL to_stb: got %0h want 0", stb_o); end
        tick();
        checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL to_cyc_end: got %0h want 0", cyc_o); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL to_cmd_ready: got %0h want 1", cmd_ready); end
    endtask

    task automatic test_rsp_stall();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h40; cmd_len = 4'd1;
        tick();
        cmd_valid = 1'b0;
        ack_i = 1'b1; dat_i = 32'h5555_AAAA;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL st_valid[%0d]: got %0h want 1", i, rsp_valid); end
            checks++; if (rsp_data !== 32'h5555_AAAA) begin errors++; $display("FAIL st_data[%0d]: got %h want 5555aaaa", i, rsp_data); end
            checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL st_last[%0d]: got %0h want 0", i, rsp_last); end
            checks++; if (stb_o !== 1'b0) begin errors++; $display("FAIL st_stb[%0d]: got %0h want 0", i, stb_o); end
            checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL st_cyc[%0d]: got %0h want 1", i, cyc_o); end
            ack_i = (i % 2 == 1); dat_i = 32'hDEAD_0000 + i;
            tick();
        end
        ack_i = 1'b0;
        rsp_ready = 1'b1;
        checks++; if (rsp_data !== 32'h5555_AAAA) begin errors++; $display("FAIL st_data_release: got %h want 5555aaaa", rsp_data); end
        tick();
        checks++; if (stb_o !== 1'b1) begin errors++; $display("FAIL st_b2_stb: got %0h want 1", stb_o); end
        checks++; if (adr_o !== 32'h41) begin errors++; $display("FAIL st_b2_adr: got %h want 00000041", adr_o); end
        ack_i = 1'b1; dat_i = 32'h1234_5678;
        tick();
        ack_i = 1'b0;
        checks++; if (rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL st_b2_data: got %h want 12345678", rsp_data); end
        checks++; if (rsp_last !== 1'b1) begin errors++; $display("FAIL st_b2_last: got %0h want 1", rsp_last); end
        tick();
        checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL st_cyc_end: got %0h want 0", cyc_o); end
    endtask

    task automatic test_reset_mid_burst();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h80; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        ack_i = 1'b1; dat_i = 32'h0BAD_BEEF;
        tick();
        ack_i = 1'b0;
        tick();                                    // beat 2 strobe outstanding
        checks++; if (stb_o !== 1'b1) begin errors++; $display("FAIL rst_pre_stb: got %0h want 1", stb_o); end
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc: got %0h want 0", cyc_o); end
        checks++; if (stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb: got %0h want 0", stb_o); end
        checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %0h want 0", we_o); end
        checks++; if (adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr: got %h want 0", adr_o); end
        checks++; if (sel_o !== 4'h0) begin errors++; $display("FAIL rst_sel: got %h want 0", sel_o); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0h want 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %0h want 1", cmd_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: got %0h want 0", rsp_valid); end
        checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc_after: got %0h want 0", cyc_o); end
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_len = 4'd0;
        wdata_valid = 1'b0; wdata = 32'h0; rsp_ready = 1'b1;
        dat_i = 32'h0; ack_i = 1'b0; err_i = 1'b0;
        test_reset();
        test_single_read();
        test_write_burst();
        test_read_err();
        test_timeout();
        test_rsp_stall();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
